// File: rtl/ccff_prog_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ccff_prog_ctrl : streams bitstream words, LSB first, into a serial    |
// | configuration chain. Optional readback compare: CCFF_READBACK_CHECK_EN|
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ccff_prog_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic              bs_valid,
  input  logic [WORD_W-1:0] bs_data,
  output logic              bs_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int POS_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(CHAIN_LEN);
  localparam logic [POS_W-1:0] C_POS_LAST = POS_W'(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_SHIFT  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [POS_W-1:0]  pos_q, pos_d, pos_inc;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic              head_q, head_d;
  logic              chain_en_q, chain_en_d;
  logic              done_q;
  logic              armed_q;
  logic              start_ok;

  // armed_q keeps the first cycle after reset release free of any action
  assign start_ok = start & armed_q;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign pos_inc  = pos_q + POS_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pos_d      = pos_q;
    sreg_d     = sreg_q;
    head_d     = head_q;
    chain_en_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bs_valid) begin
          head_d     = bs_data[0];
          sreg_d     = bs_data >> 1;
          pos_d      = '0;
          chain_en_d = 1'b1;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_inc;
        pos_d = pos_inc;
        if (cnt_inc == C_CNT_LAST) begin
          state_d = S_FINISH;
        end else if (pos_inc == C_POS_LAST) begin
          state_d = S_FETCH;
        end else begin
          head_d     = sreg_q[0];
          sreg_d     = sreg_q >> 1;
          chain_en_d = 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pos_q      <= '0;
      sreg_q     <= '0;
      head_q     <= 1'b0;
      chain_en_q <= 1'b0;
      done_q     <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      sreg_q     <= sreg_d;
      head_q     <= head_d;
      chain_en_q <= chain_en_d;
      done_q     <= (state_q == S_FINISH);
      armed_q    <= 1'b1;
    end
  end

  assign bs_ready  = (state_q == S_FETCH);
  assign busy      = (state_q != S_IDLE);
  assign ccff_head = head_q;
  assign chain_en  = chain_en_q;
  assign done      = done_q;

`ifdef CCFF_READBACK_CHECK_EN
  logic mode_q;
  logic err_q;

  // In a verify pass the tail returns the bit now being re-driven on the head
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      mode_q <= 1'b0;
      err_q  <= 1'b0;
    end else if ((state_q == S_IDLE) && start_ok) begin
      mode_q <= verify;
      if (verify) begin
        err_q <= 1'b0;
      end
    end else if ((state_q == S_SHIFT) && mode_q && (ccff_tail != head_q)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_inputs;
  assign unused_inputs = verify ^ ccff_tail;
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccff_prog_ctrl.sv
`default_nettype none
// Scoreboarded bench for ccff_prog_ctrl with a behavioural chain and stream model.
module tb_ccff_prog_ctrl;

  localparam int N  = 12;
  localparam int W  = 8;
  localparam int NW = (N + W - 1) / W;

  logic         prog_clk = 1'b0;
  logic         pReset   = 1'b1;
  logic         start    = 1'b0;
  logic         verify   = 1'b0;
  logic         bs_valid = 1'b0;
  logic [W-1:0] bs_data  = '0;
  logic         bs_ready, ccff_head, ccff_tail, chain_en, busy, done, err;

  ccff_prog_ctrl #(.CHAIN_LEN(N), .WORD_W(W)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .start    (start),
    .verify   (verify),
    .bs_valid (bs_valid),
    .bs_data  (bs_data),
    .bs_ready (bs_ready),
    .ccff_head(ccff_head),
    .ccff_tail(ccff_tail),
    .chain_en (chain_en),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 prog_clk = ~prog_clk;

  int cyc = 0;
  always @(posedge prog_clk) cyc <= cyc + 1;

  // Physical chain: head enters at bit 0, tail leaves from bit N-1
  logic [N-1:0] chain = '0;
  always @(posedge prog_clk) if (chain_en) chain <= {chain[N-2:0], ccff_head};
  assign ccff_tail = chain[N-1];

  typedef struct {
    int cyc;
    bit err;
  } done_t;

  bit    exp_head_q[$];
  done_t exp_done_q[$];
  done_t d;
  bit    err_m = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  prev_head = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge prog_clk) begin
    if (!pReset) begin
      if (chain_en) begin
        if (exp_head_q.size() == 0) check("unexpected_shift", 1, 0);
        else check("head_bit", ccff_head, exp_head_q.pop_front());
      end else begin
        check("head_hold", ccff_head, prev_head);
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          d = exp_done_q.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("err_at_done", err, d.err);
        end
      end
    end
    prev_head <= ccff_head;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bs_ready"}, bs_ready, 0);
    check({tag, "_ccff_head"}, ccff_head, 0);
    check({tag, "_chain_en"}, chain_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // One programming pass driven on a fixed schedule; called at posedge+1 while idle
  task automatic run_pass(input bit vfy, input logic [NW*W-1:0] stream,
                          input int gap0, input int gmax, input bit noise);
    int t0, fetch_total, nb, gap;
    fetch_total = 0;
    for (int k = 0; k < N; k++) exp_head_q.push_back(stream[k]);
`ifdef CCFF_READBACK_CHECK_EN
    if (vfy) begin
      err_m = 1'b0;
      for (int k = 0; k < N; k++) if (chain[N-1-k] != stream[k]) err_m = 1'b1;
    end
`endif
    start  = 1'b1;
    verify = vfy;
    @(posedge prog_clk); #1;
    start = 1'b0;
    t0 = cyc;
    for (int w = 0; w < NW; w++) begin
      gap = (w == 0) ? gap0 : int'($urandom_range(gmax, 0));
      for (int g = 0; g < gap; g++) begin
        bs_valid = 1'b0;
        bs_data  = W'($urandom);
        start    = noise ? 1'($urandom) : 1'b0;
        verify   = 1'($urandom);
        check("ready_in_fetch", bs_ready, 1);
        check("chain_en_in_fetch", chain_en, 0);
        @(posedge prog_clk); #1;
      end
      bs_valid = 1'b1;
      bs_data  = stream[w*W +: W];
      check("ready_at_accept", bs_ready, 1);
      @(posedge prog_clk); #1;
      fetch_total += gap + 1;
      nb = (N - w * W < W) ? (N - w * W) : W;
      for (int s = 0; s < nb; s++) begin
        bs_valid = noise ? 1'($urandom) : 1'b0;
        bs_data  = W'($urandom);
        start    = noise ? 1'($urandom) : 1'b0;
        verify   = 1'($urandom);
        check("ready_in_shift", bs_ready, 0);
        check("busy_in_shift", busy, 1);
        @(posedge prog_clk); #1;
      end
    end
    start    = 1'b0;
    verify   = 1'b0;
    bs_valid = 1'b0;
    d.cyc = t0 + fetch_total + N + 1;
    d.err = err_m;
    exp_done_q.push_back(d);
    check("busy_in_finish", busy, 1);
    check("chain_en_in_finish", chain_en, 0);
    @(posedge prog_clk); #1;
    check("busy_after_pass", busy, 0);
    @(posedge prog_clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge prog_clk);
    #1;
    check_reset_outputs("por");
    pReset = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1;

    run_pass(1'b0, {8'h03, 8'hA5}, 0, 0, 1'b0);
    run_pass(1'b0, {8'h03, 8'hFF}, 0, 0, 1'b0);
    run_pass(1'b0, {8'hF3, 8'h5A}, 5, 0, 1'b0);
    run_pass(1'b0, {8'h0C, 8'h3C}, 0, 0, 1'b1);
    run_pass(1'b1, {8'h0C, 8'h3C}, 0, 0, 1'b0);
    run_pass(1'b1, {8'h0C, 8'h3D}, 0, 0, 1'b0);
    run_pass(1'b0, {8'h0C, 8'h3D}, 0, 0, 1'b0);
    run_pass(1'b1, {8'h0C, 8'h3D}, 1, 2, 1'b1);

    for (int p = 0; p < 24; p++) begin
      run_pass(1'($urandom_range(3, 0) == 0), (NW*W)'($urandom),
               int'($urandom_range(3, 0)), 3, 1'($urandom));
      if ($urandom_range(1, 0) == 1) begin
        @(posedge prog_clk); #1;
      end
    end

    // Abort a pass with an asynchronous reset while bit 3 is being shifted
    for (int k = 0; k < N; k++) exp_head_q.push_back(k < W ? 1'(8'h5A >> k) : 1'b0);
    start = 1'b1;
    @(posedge prog_clk); #1;
    start    = 1'b0;
    bs_valid = 1'b1;
    bs_data  = 8'h5A;
    @(posedge prog_clk); #1;
    bs_valid = 1'b0;
    repeat (3) @(posedge prog_clk);
    #3;
    pReset = 1'b1;
    #1;
    check_reset_outputs("async");
    exp_head_q.delete();
    err_m = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1;
    pReset = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    run_pass(1'b0, {8'h81, 8'h7E}, 2, 1, 1'b1);

    repeat (4) @(posedge prog_clk);
    #1;
    check("pending_done", exp_done_q.size(), 0);
    check("pending_head", exp_head_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccff_prog_ctrl.md
CCFF_PROG_CTRL -- requirements
Module: ccff_prog_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 8, giving the configuration-chain length in bits (legal range 1..4096).
REQ-002 SHALL have parameter WORD_W, default 8, giving the bitstream word width in bits.
REQ-003 prog_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 pReset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a programming pass; sampled only in IDLE.
REQ-006 verify  input  1  sampled with start; 1 selects a readback-compare pass instead of a load pass.
REQ-007 bs_valid  input  1  a bitstream word is present on bs_data.
REQ-008 bs_data  input  WORD_W  bitstream word; bit 0 is shifted first.
REQ-009 bs_ready  output  1  controller accepts a word this cycle.
REQ-010 ccff_head  output  1  registered serial data to the chain head.
REQ-011 ccff_tail  input  1  serial data returned from the chain tail.
REQ-012 chain_en  output  1  registered chain shift enable; the chain advances exactly one bit on each prog_clk edge where chain_en=1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at the end of a pass.
REQ-015 err  output  1  sticky readback-mismatch flag.

Function
REQ-016 SHALL implement the states IDLE, FETCH, SHIFT and FINISH.
REQ-017 IDLE: on start=1, SHALL clear the bit counter, latch verify into a mode register, clear err if verify=1, and go to FETCH.
REQ-018 FETCH: SHALL drive bs_ready=1 and chain_en=0.
REQ-019 FETCH: on bs_valid&bs_ready, SHALL load bs_data into the shift register and go to SHIFT the next cycle.
REQ-020 FETCH: SHALL NOT register a transfer while bs_valid=0, and SHALL wait indefinitely.
REQ-021 SHIFT: each cycle SHALL present the shift-register LSB on ccff_head with chain_en=1, shift right by one, and increment the bit counter.
REQ-022 SHIFT: after WORD_W bits, SHALL return to FETCH.
REQ-023 SHIFT: when the bit counter reaches CHAIN_LEN, SHALL go to FINISH regardless of the word position; the unshifted upper bits of the last word are discarded.
REQ-024 Word count per pass SHALL be ceil(CHAIN_LEN/WORD_W).
REQ-025 bs_ready SHALL be 0 outside FETCH.
REQ-026 chain_en SHALL be 0 outside SHIFT.
REQ-027 ccff_head SHALL hold its last value when chain_en=0.
REQ-028 FINISH: SHALL pulse done=1 for one cycle and return to IDLE.
REQ-029 Total pass latency from start to done SHALL be CHAIN_LEN shift cycles plus one FETCH cycle per word (with bs_valid held high) plus 2.
REQ-030 start asserted while busy=1 SHALL be ignored.
REQ-031 The bit counter SHALL be ceil(log2(CHAIN_LEN+1)) bits wide and SHALL never wrap.

Reset
REQ-032 pReset=1 SHALL force state IDLE and set bs_ready, ccff_head, chain_en, busy, done and err to 0 immediately, independent of prog_clk.
REQ-033 Reset during FETCH or SHIFT SHALL abort the pass with no done pulse; the chain contents are then undefined and a new load pass is required.
REQ-034 Deassertion of pReset SHALL be synchronised externally; the block SHALL take no action in the first cycle after release.

Configuration
REQ-035 Macro CCFF_READBACK_CHECK_EN SHALL control the readback-compare feature.
REQ-036 With CCFF_READBACK_CHECK_EN defined, a verify pass SHALL shift the same bitstream again and, on each SHIFT cycle, compare ccff_tail against the bit being driven on ccff_head in that cycle.
REQ-037 With CCFF_READBACK_CHECK_EN defined, any mismatch SHALL set err, and err SHALL remain set until the next verify start or pReset.
REQ-038 With CCFF_READBACK_CHECK_EN defined, a verify pass SHALL leave the chain contents unchanged.
REQ-039 Without CCFF_READBACK_CHECK_EN, verify SHALL be ignored (every pass is a load), err SHALL be tied to 0, and no compare logic SHALL be synthesised.

Verification
REQ-040 CHAIN_LEN=8, WORD_W=8, start, bs_data=8'hA5 with bs_valid held high -> ccff_head sequence 1,0,1,0,0,1,0,1 with chain_en high for exactly 8 cycles; done at cycle 11.
REQ-041 CHAIN_LEN=12, words 8'hFF then 8'h03 -> 12 chain_en cycles, 4 upper bits of the second word discarded, 2 FETCH cycles, one done pulse.
REQ-042 bs_valid low for 5 cycles in FETCH -> bs_ready stays 1, chain_en stays 0, no counter change; the pass resumes on bs_valid.
REQ-043 pReset pulse mid-SHIFT at bit 3 -> all outputs 0 asynchronously and no done; a subsequent start runs a full pass.
REQ-044 With CCFF_READBACK_CHECK_EN: load 8'h3C, then verify with 8'h3C -> err=0; verify with 8'h3D -> err=1 and remains 1 after done.
REQ-045 start pulsed while busy=1 -> ignored; the pass completes with exactly one done pulse.
